// File: rtl/shift32_iter.sv
// shift32_iter -- multi-cycle iterative shifter (SLL / SRL / SRA).
//
// The operand is shifted by up to STEP bit positions per clock instead of
// going through a full single-cycle barrel shifter. The control FSM talks to
// this block with a START / BUSY / DONE handshake. The result is registered.
//
// Mode encoding {right_i, arith_i}:
//   00, 01 -> left logical
//   10     -> right logical
//   11     -> right arithmetic
//
// Ports:
//   clk_i    in   1             clock; all state changes on the rising edge
//   rst_i    in   1             asynchronous active-high reset
//   start_i  in   1             request; sampled only while busy_o = 0
//   d_i      in   WIDTH         operand, captured when a request is accepted
//   shamt_i  in   clog2(WIDTH)  shift amount, captured when a request is accepted
//   right_i  in   1             1 = right shift, 0 = left shift
//   arith_i  in   1             1 = sign fill on a right shift (ignored on left)
//   busy_o   out  1             high whenever the FSM is not idle
//   done_o   out  1             one-cycle pulse; res_o is final in this cycle
//   res_o    out  WIDTH         work register: intermediate while shifting,
//                               final from the done cycle until the next accept
module shift32_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [WIDTH-1:0]         d_i,
  input  logic [$clog2(WIDTH)-1:0] shamt_i,
  input  logic                     right_i,
  input  logic                     arith_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WIDTH-1:0]         res_o
);

  localparam int SW = $clog2(WIDTH);

  // Largest per-cycle shift that can actually occur: the remaining count never
  // exceeds WIDTH-1, so a STEP equal to WIDTH is clipped.
  localparam int KMAX = (STEP < WIDTH) ? STEP : WIDTH - 1;

  // STEP held in SW+1 bits so that STEP == WIDTH is still representable.
  localparam logic [SW:0] STEP_W = (SW + 1)'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]    rem_q,  rem_d;
  logic             right_q, right_d;
  // Vacated MSBs are filled with ones only for a right arithmetic shift of a
  // negative operand; the decision is made once, at capture time.
  logic             fill_q,  fill_d;

  logic [SW-1:0]    k;
  logic [SW-1:0]    rem_after;
  logic [WIDTH-1:0] step_res;
  logic [WIDTH-1:0] cand [0:KMAX];

  // One candidate per possible per-cycle shift distance; k selects among them.
  genvar gi;
  generate
    for (gi = 0; gi <= KMAX; gi++) begin : g_cand
      localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> gi);
      assign cand[gi] = right_q ? ((work_q >> gi) | (fill_q ? FILL_MASK : '0))
                                : (work_q << gi);
    end
  endgenerate

  // k = min(STEP, rem)
  always_comb begin
    k = rem_q;
    if ({1'b0, rem_q} >= STEP_W) begin
      k = STEP_W[SW-1:0];
    end
  end

  assign rem_after = rem_q - k;

  always_comb begin
    step_res = cand[0];
    for (int i = 1; i <= KMAX; i++) begin
      if (k == SW'(i)) begin
        step_res = cand[i];
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    right_d = right_q;
    fill_d  = fill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          work_d  = d_i;
          rem_d   = shamt_i;
          right_d = right_i;
          fill_d  = right_i & arith_i & d_i[WIDTH-1];
          state_d = (shamt_i != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        work_d  = step_res;
        rem_d   = rem_after;
        state_d = (rem_after == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        // start_i is deliberately not looked at here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      right_q <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      right_q <= right_d;
      fill_q  <= fill_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign res_o  = work_q;

endmodule

// File: tb/tb_shift32_iter.sv
// Directed and randomized checks of shift32_iter (WIDTH=32, STEP=4):
// result values, DONE latency, BUSY duration, ignored START while busy,
// back-to-back throughput with START held, and asynchronous reset abort.
module tb_shift32_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] d_in;
  logic [4:0]  shamt;
  logic        right;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int n_cmp;
  int n_bad;

  shift32_iter #(.WIDTH(32), .STEP(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .d_i     (d_in),
    .shamt_i (shamt),
    .right_i (right),
    .arith_i (arith),
    .busy_o  (busy),
    .done_o  (done),
    .res_o   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to DONE. Samples are taken 1 time unit
  // after each rising edge; the sample right after the accepting edge is
  // cycle 1, so the cycle index where DONE is seen is the latency L.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] sh,
                        input logic r, input logic a, input logic [31:0] exp_res,
                        input int exp_lat, input int exp_busy);
    int lat;
    int nbusy;
    logic [31:0] res_done;
    @(negedge clk);
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    start = 1'b1; d_in = d; shamt = sh; right = r; arith = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy) nbusy++;
    res_done = res;
    $display("op %s d=%h sh=%0d r=%b a=%b res=%h lat=%0d", tag, d, sh, r, a, res_done, lat);
    check_eq({tag, "_res"}, res_done, exp_res);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (exp_busy > 0) check_eq({tag, "_busy"}, 32'(nbusy), 32'(exp_busy));
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_hold"}, res, exp_res);
  endtask

  initial begin
    int ndone;
    int first_idx;
    int second_idx;
    logic [31:0] res_at_done;
    logic [31:0] rd;
    logic [4:0]  rs;
    logic        rr;
    logic        ra;
    logic [31:0] gold;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; start = 1'b0; d_in = '0; shamt = '0; right = 1'b0; arith = 1'b0;

    #1;
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    check_eq("reset_res", res, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    run_op("sll31", 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 9, 9);
    run_op("sra4",  32'h8000_00F0, 5'd4,  1'b1, 1'b1, 32'hF800_000F, 2, 2);
    run_op("srl4",  32'h8000_00F0, 5'd4,  1'b1, 1'b0, 32'h0800_000F, 2, 2);
    run_op("sh0",   32'hDEAD_BEEF, 5'd0,  1'b1, 1'b1, 32'hDEAD_BEEF, 1, 1);
    run_op("sll8a", 32'h0000_000F, 5'd8,  1'b0, 1'b1, 32'h0000_0F00, 3, 3);
    run_op("sra31", 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 9, 9);
    run_op("srl5",  32'h8000_0000, 5'd5,  1'b1, 1'b0, 32'h0400_0000, 3, 3);
    run_op("sra7p", 32'h7000_0000, 5'd7,  1'b1, 1'b1, 32'h00E0_0000, 3, 3);

    // START while busy is ignored
    @(negedge clk);
    start = 1'b1; d_in = 32'h0000_00FF; shamt = 5'd8; right = 1'b0; arith = 1'b0;
    @(posedge clk);
    #1;
    d_in = 32'hFFFF_FFFF; shamt = 5'd4; right = 1'b1; arith = 1'b1;
    ndone = 0;
    res_at_done = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) start = 1'b0;
      if (done) begin
        ndone++;
        res_at_done = res;
      end
    end
    $display("op busy_start res=%h done_pulses=%0d", res_at_done, ndone);
    check_eq("busy_start_res", res_at_done, 32'h0000_FF00);
    check_eq("busy_start_ndone", 32'(ndone), 32'd1);

    // START held high: back-to-back operations every L+1 cycles (L=2 here)
    @(negedge clk);
    start = 1'b1; d_in = 32'h0000_00F0; shamt = 5'd4; right = 1'b1; arith = 1'b0;
    first_idx = -1;
    second_idx = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (first_idx < 0) first_idx = i;
        else if (second_idx < 0) begin
          second_idx = i;
          start = 1'b0;
        end
      end
    end
    $display("op held_start first=%0d second=%0d res=%h", first_idx, second_idx, res);
    check_eq("held_gap", 32'(second_idx - first_idx), 32'd3);
    check_eq("held_res", res, 32'h0000_000F);
    check_eq("held_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; d_in = 32'h0000_0001; shamt = 5'd31; right = 1'b0; arith = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("op rst_abort busy=%b done=%b res=%h", busy, done, res);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_res", res, 32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (i == 3) rst = 1'b0;
    end
    check_eq("rst_no_done", 32'(ndone), 32'd0);
    run_op("srl28", 32'hF000_0000, 5'd28, 1'b1, 1'b0, 32'h0000_000F, 8, 8);

    // Randomized sweep against the language shift operators
    for (int n = 0; n < 400; n++) begin
      rd = $urandom;
      rs = 5'($urandom_range(0, 31));
      rr = 1'($urandom_range(0, 1));
      ra = 1'($urandom_range(0, 1));
      if (!rr)      gold = rd << rs;
      else if (ra)  gold = 32'($signed(rd) >>> rs);
      else          gold = rd >> rs;
      run_op($sformatf("rnd%0d", n), rd, rs, rr, ra, gold, 1 + (int'(rs) + 3) / 4, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
